// File: rtl/flash_ctrl_pkg.sv
// Shared constants, encodings and helpers for the SPI NOR flash sequencer.
package flash_ctrl_pkg;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned CNT_W     = 9;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned POLL_W    = 20;
  localparam int unsigned PAGE_SIZE = 256;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'h20;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_PP   = 2'd1,
    OP_SE   = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_POLL_CMD,
    ST_POLL_RD,
    ST_DONE
  } state_e;

  // Byte count outside 1..PAGE_SIZE is rejected for read and program.
  function automatic logic len_bad(input logic [CNT_W-1:0] num);
    return (num == '0) || (num > CNT_W'(PAGE_SIZE));
  endfunction

endpackage

// File: rtl/flash_ctrl_seq_cnt.sv
// Byte, address-index and status-poll counters with terminal-count flags.
module flash_ctrl_seq_cnt
  import flash_ctrl_pkg::*;
#(
  parameter logic [POLL_W-1:0] P_POLL_MAX = 20'd1000000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clr,
  input  logic             inc_byte,
  input  logic             inc_addr,
  input  logic             inc_poll,
  input  logic [CNT_W-1:0] num,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [IDX_W-1:0] addr_idx,
  output logic             byte_first_c,
  output logic             byte_last_c,
  output logic             byte_done_c,
  output logic             addr_done_c,
  output logic             poll_last_c
);

  logic [POLL_W-1:0] poll_cnt;

  assign byte_first_c = (byte_cnt == '0);
  assign byte_last_c  = (byte_cnt == CNT_W'(num - CNT_W'(1)));
  assign byte_done_c  = (byte_cnt == num);
  assign addr_done_c  = (addr_idx == IDX_W'(3));
  assign poll_last_c  = (poll_cnt == POLL_W'(P_POLL_MAX - POLL_W'(1)));

  // Counters saturate at their terminal values; no wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      byte_cnt <= '0;
      addr_idx <= '0;
      poll_cnt <= '0;
    end else begin
      if (inc_byte && !byte_done_c) byte_cnt <= byte_cnt + CNT_W'(1);
      if (inc_addr && !addr_done_c) addr_idx <= addr_idx + IDX_W'(1);
      if (inc_poll && !poll_last_c) poll_cnt <= poll_cnt + POLL_W'(1);
    end
  end

endmodule

// File: rtl/flash_ctrl.sv
// SPI NOR flash sequencer: expands read / page program / sector erase
// requests into byte transactions for a byte-level SPI driver.
module flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter logic [POLL_W-1:0] P_POLL_MAX = 20'd1000000,
  parameter logic [7:0]        P_CMD_READ = CMD_READ,
  parameter logic [7:0]        P_CMD_PP   = CMD_PP,
  parameter logic [7:0]        P_CMD_SE   = CMD_SE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_operation_type,
  input  logic [ADDR_W-1:0] i_operation_addr,
  input  logic [CNT_W-1:0]  i_operation_num,
  input  logic              i_operation_valid,
  output logic              o_operation_ready,
  input  logic [7:0]        i_write_data,
  input  logic              i_write_sop,
  input  logic              i_write_eop,
  input  logic              i_write_valid,
  output logic              o_write_ready,
  output logic [7:0]        o_read_data,
  output logic              o_read_sop,
  output logic              o_read_eop,
  output logic              o_read_valid,
  output logic [7:0]        o_spi_data,
  output logic              o_spi_last,
  output logic              o_spi_valid,
  input  logic              i_spi_ready,
  input  logic [7:0]        i_spi_rdata,
  input  logic              i_spi_rvalid,
  output logic              o_busy,
  output logic              o_error
);

  state_e            state;
  op_e               op_q;
  op_e               op_in_c;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  num_q;
  logic              err_q;
  logic              outstanding;
  logic              spi_valid_q;
  logic              spi_last_q;
  logic [7:0]        spi_data_q;

  logic [CNT_W-1:0]  byte_cnt;
  logic [IDX_W-1:0]  addr_idx;
  logic              byte_first_c, byte_last_c, byte_done_c, addr_done_c, poll_last_c;

  logic              accept_c, prog_win_c, spi_fire_c, rvalid_c;
  logic              tx_en_c, tx_last_c;
  logic [7:0]        tx_data_c;

  assign op_in_c    = op_e'(i_operation_type);
  assign accept_c   = i_operation_valid && o_operation_ready;
  // Program bytes bypass the byte register and go straight to the driver.
  assign prog_win_c = (state == ST_DATA) && (op_q == OP_PP) && !outstanding && !byte_done_c;
  assign spi_fire_c = o_spi_valid && i_spi_ready;
  assign rvalid_c   = i_spi_rvalid && outstanding;

  assign o_spi_valid   = prog_win_c ? i_write_valid : spi_valid_q;
  assign o_spi_data    = prog_win_c ? i_write_data  : spi_data_q;
  assign o_spi_last    = prog_win_c ? byte_last_c   : spi_last_q;
  assign o_write_ready = prog_win_c && i_spi_ready;

  flash_ctrl_seq_cnt #(.P_POLL_MAX(P_POLL_MAX)) u_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .clr          (accept_c),
    .inc_byte     (spi_fire_c && (state == ST_DATA)),
    .inc_addr     (spi_fire_c && (state == ST_ADDR)),
    .inc_poll     (rvalid_c && (state == ST_POLL_RD) && i_spi_rdata[0]),
    .num          (num_q),
    .byte_cnt     (byte_cnt),
    .addr_idx     (addr_idx),
    .byte_first_c (byte_first_c),
    .byte_last_c  (byte_last_c),
    .byte_done_c  (byte_done_c),
    .addr_done_c  (addr_done_c),
    .poll_last_c  (poll_last_c)
  );

  // Next byte to issue from the current state.
  always_comb begin
    tx_en_c   = 1'b1;
    tx_data_c = 8'h00;
    tx_last_c = 1'b0;
    case (state)
      ST_WREN: begin
        tx_data_c = CMD_WREN;
        tx_last_c = 1'b1;
      end
      ST_CMD: begin
        case (op_q)
          OP_READ: tx_data_c = P_CMD_READ;
          OP_PP:   tx_data_c = P_CMD_PP;
          default: tx_data_c = P_CMD_SE;
        endcase
      end
      ST_ADDR: begin
        case (addr_idx)
          2'd0:    tx_data_c = addr_q[23:16];
          2'd1:    tx_data_c = addr_q[15:8];
          default: tx_data_c = addr_q[7:0];
        endcase
        tx_last_c = (addr_idx == 2'd2) && (op_q == OP_SE);
      end
      ST_DATA: begin
        tx_en_c   = (op_q == OP_READ);
        tx_last_c = byte_last_c;
      end
      ST_POLL_CMD: tx_data_c = CMD_RDSR;
      ST_POLL_RD:  tx_last_c = 1'b1;
      default:     tx_en_c   = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= ST_IDLE;
      op_q              <= OP_READ;
      addr_q            <= '0;
      num_q             <= '0;
      err_q             <= 1'b0;
      outstanding       <= 1'b0;
      spi_valid_q       <= 1'b0;
      spi_data_q        <= 8'h00;
      spi_last_q        <= 1'b0;
      o_operation_ready <= 1'b1;
      o_busy            <= 1'b0;
      o_error           <= 1'b0;
      o_read_data       <= 8'h00;
      o_read_sop        <= 1'b0;
      o_read_eop        <= 1'b0;
      o_read_valid      <= 1'b0;
    end else begin
      o_error      <= 1'b0;
      o_read_valid <= 1'b0;
      o_read_sop   <= 1'b0;
      o_read_eop   <= 1'b0;

      // At most one byte in flight: issue only when nothing is outstanding.
      if (spi_valid_q && i_spi_ready) begin
        spi_valid_q <= 1'b0;
      end else if (tx_en_c && !spi_valid_q && !outstanding) begin
        spi_valid_q <= 1'b1;
        spi_data_q  <= tx_data_c;
        spi_last_q  <= tx_last_c;
      end
      if (spi_fire_c)    outstanding <= 1'b1;
      else if (rvalid_c) outstanding <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            op_q              <= op_in_c;
            addr_q            <= i_operation_addr;
            num_q             <= i_operation_num;
            o_operation_ready <= 1'b0;
            o_busy            <= 1'b1;
            if (op_in_c == OP_RSVD || (op_in_c != OP_SE && len_bad(i_operation_num))) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else if (op_in_c == OP_READ) begin
              state <= ST_CMD;
            end else begin
              state <= ST_WREN;
            end
          end
        end
        ST_WREN: if (rvalid_c) state <= ST_CMD;
        ST_CMD:  if (rvalid_c) state <= ST_ADDR;
        ST_ADDR: begin
          if (rvalid_c && addr_done_c) state <= (op_q == OP_SE) ? ST_POLL_CMD : ST_DATA;
        end
        ST_DATA: begin
          // Framing errors are flagged but length is governed by num alone.
          if (prog_win_c && i_write_valid && i_spi_ready &&
              ((i_write_sop != byte_first_c) || (i_write_eop != byte_last_c)))
            err_q <= 1'b1;
          if (rvalid_c) begin
            if (op_q == OP_READ) begin
              o_read_valid <= 1'b1;
              o_read_data  <= i_spi_rdata;
              o_read_sop   <= (byte_cnt == CNT_W'(1));
              o_read_eop   <= byte_done_c;
            end
            if (byte_done_c) state <= (op_q == OP_READ) ? ST_DONE : ST_POLL_CMD;
          end
        end
        ST_POLL_CMD: if (rvalid_c) state <= ST_POLL_RD;
        ST_POLL_RD: begin
          if (rvalid_c) begin
            if (!i_spi_rdata[0]) begin
              state <= ST_DONE;
            end else if (poll_last_c) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_POLL_CMD;
            end
          end
        end
        ST_DONE: begin
          o_error           <= err_q;
          err_q             <= 1'b0;
          state             <= ST_IDLE;
          o_operation_ready <= 1'b1;
          o_busy            <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_ctrl.sv
// Scoreboard bench for flash_ctrl: a reference model builds the expected SPI,
// read and error streams per operation; independent monitors consume them.
module tb_flash_ctrl;

  localparam int POLL_MAX = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_operation_type;
  logic [23:0] i_operation_addr;
  logic [8:0]  i_operation_num;
  logic        i_operation_valid;
  logic        o_operation_ready;
  logic [7:0]  i_write_data;
  logic        i_write_sop, i_write_eop, i_write_valid;
  logic        o_write_ready;
  logic [7:0]  o_read_data;
  logic        o_read_sop, o_read_eop, o_read_valid;
  logic [7:0]  o_spi_data;
  logic        o_spi_last, o_spi_valid;
  logic        i_spi_ready;
  logic [7:0]  i_spi_rdata;
  logic        i_spi_rvalid;
  logic        o_busy, o_error;

  always #50 clk = ~clk;

  flash_ctrl #(.P_POLL_MAX(20'd4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_operation_type(i_operation_type), .i_operation_addr(i_operation_addr),
    .i_operation_num(i_operation_num), .i_operation_valid(i_operation_valid),
    .o_operation_ready(o_operation_ready),
    .i_write_data(i_write_data), .i_write_sop(i_write_sop), .i_write_eop(i_write_eop),
    .i_write_valid(i_write_valid), .o_write_ready(o_write_ready),
    .o_read_data(o_read_data), .o_read_sop(o_read_sop), .o_read_eop(o_read_eop),
    .o_read_valid(o_read_valid),
    .o_spi_data(o_spi_data), .o_spi_last(o_spi_last), .o_spi_valid(o_spi_valid),
    .i_spi_ready(i_spi_ready), .i_spi_rdata(i_spi_rdata), .i_spi_rvalid(i_spi_rvalid),
    .o_busy(o_busy), .o_error(o_error)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] resp;
  } spi_exp_t;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } strm_t;

  spi_exp_t   spi_q[$];
  strm_t      rd_q[$];
  strm_t      wr_q[$];
  bit         err_q[$];
  logic [7:0] fixed_q[$];

  int checks = 0;
  int errors = 0;
  int spi_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] next_data();
    if (fixed_q.size() > 0) return fixed_q.pop_front();
    return 8'($urandom);
  endfunction

  task automatic push_spi(input logic [7:0] d, input logic l, input logic [7:0] r);
    spi_exp_t e;
    e.data = d; e.last = l; e.resp = r;
    spi_q.push_back(e);
  endtask

  // Reference model: expected traffic built from the operation's rules.
  task automatic issue_op(input int typ, input logic [23:0] addr, input int num,
                          input int busy_polls, input bit bad_frame);
    bit         err;
    bit         got;
    int         pairs;
    strm_t      w;
    logic [7:0] op;
    logic [7:0] d;
    logic [7:0] st;
    err = (typ == 3) || (typ != 2 && (num < 1 || num > 256));
    if (!err) begin
      op = (typ == 0) ? 8'h03 : (typ == 1) ? 8'h02 : 8'h20;
      if (typ != 0) push_spi(8'h06, 1'b1, 8'($urandom));
      push_spi(op, 1'b0, 8'($urandom));
      push_spi(addr[23:16], 1'b0, 8'($urandom));
      push_spi(addr[15:8], 1'b0, 8'($urandom));
      push_spi(addr[7:0], typ == 2, 8'($urandom));
      if (typ != 2) begin
        for (int i = 0; i < num; i++) begin
          d = next_data();
          w.data = d; w.sop = (i == 0); w.eop = (i == num - 1);
          if (typ == 0) begin
            push_spi(8'h00, i == num - 1, d);
            rd_q.push_back(w);
          end else begin
            if (bad_frame) begin
              if (num >= 2) w.eop = (i == num - 2);
              else          w.sop = 1'b0;
            end
            wr_q.push_back(w);
            push_spi(d, i == num - 1, 8'($urandom));
          end
        end
      end
      if (typ != 0) begin
        pairs = (busy_polls >= POLL_MAX) ? POLL_MAX : busy_polls + 1;
        for (int p = 0; p < pairs; p++) begin
          push_spi(8'h05, 1'b0, 8'($urandom));
          st = {7'($urandom), 1'b0};
          if (p < busy_polls) st[0] = 1'b1;
          push_spi(8'h00, 1'b1, st);
        end
        if (busy_polls >= POLL_MAX) err = 1'b1;
      end
      if (typ == 1 && bad_frame) err = 1'b1;
    end
    err_q.push_back(err);

    @(posedge clk); #1;
    i_operation_type  = 2'(typ);
    i_operation_addr  = addr;
    i_operation_num   = 9'(num);
    i_operation_valid = 1'b1;
    got = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (o_operation_ready) begin got = 1'b1; break; end
    end
    chk("req_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    i_operation_valid = 1'b0;
    i_operation_type  = 2'($urandom);
    i_operation_num   = 9'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    repeat (5000) begin
      @(negedge clk);
      if (o_operation_ready) begin got = 1'b1; break; end
    end
    chk({name, "_done"}, 32'(got), 32'd1);
    @(negedge clk);
    chk({name, "_spi_left"}, 32'(spi_q.size()), 32'd0);
    chk({name, "_rd_left"},  32'(rd_q.size()),  32'd0);
    chk({name, "_wr_left"},  32'(wr_q.size()),  32'd0);
    chk({name, "_err_left"}, 32'(err_q.size()), 32'd0);
  endtask

  // SPI driver model + byte scoreboard.
  initial begin
    spi_exp_t   e;
    bit         pend;
    int         wait_n;
    logic [7:0] pend_data;
    pend = 1'b0; wait_n = 0; pend_data = 8'h00;
    i_spi_ready = 1'b0; i_spi_rvalid = 1'b0; i_spi_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      i_spi_rvalid = 1'b0;
      if (i_rst) begin
        pend = 1'b0;
      end else if (pend) begin
        if (wait_n == 0) begin
          i_spi_rvalid = 1'b1;
          i_spi_rdata  = pend_data;
          pend = 1'b0;
        end else begin
          wait_n--;
        end
      end
      i_spi_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!i_rst && o_spi_valid) begin
        chk("one_outstanding", 32'(pend), 32'd0);
        if (i_spi_ready) begin
          spi_seen++;
          pend      = 1'b1;
          wait_n    = $urandom_range(0, 2);
          pend_data = 8'($urandom);
          if (spi_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spi_unexpected: got byte %0h last %0b with nothing expected",
                     o_spi_data, o_spi_last);
          end else begin
            e = spi_q.pop_front();
            chk("spi_byte", {23'd0, o_spi_last, o_spi_data}, {23'd0, e.last, e.data});
            pend_data = e.resp;
          end
        end
      end
    end
  end

  // Program data source.
  initial begin
    i_write_valid = 1'b0; i_write_data = 8'h00; i_write_sop = 1'b0; i_write_eop = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        i_write_valid = 1'b1;
        i_write_data  = wr_q[0].data;
        i_write_sop   = wr_q[0].sop;
        i_write_eop   = wr_q[0].eop;
      end else begin
        i_write_valid = 1'b0;
      end
      @(negedge clk);
      if (i_write_valid && o_write_ready && wr_q.size() > 0) void'(wr_q.pop_front());
    end
  end

  // Read stream monitor.
  initial begin
    strm_t e;
    forever begin
      @(negedge clk);
      if (!i_rst && o_read_valid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_unexpected: got %0h with nothing expected", o_read_data);
        end else begin
          e = rd_q.pop_front();
          chk("read_byte", {22'd0, o_read_sop, o_read_eop, o_read_data},
                           {22'd0, e.sop, e.eop, e.data});
        end
      end
    end
  end

  // Completion / error monitor: o_error may only pulse as busy drops.
  initial begin
    bit prev_busy;
    bit exp_err;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (prev_busy && !o_busy) begin
          if (err_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL op_unexpected: completion with nothing expected");
          end else begin
            exp_err = err_q.pop_front();
            chk("op_error", 32'(o_error), 32'(exp_err));
          end
        end else if (o_error) begin
          checks++; errors++;
          $display("FAIL stray_error: got o_error=1 expected 0 outside completion");
        end
      end
      prev_busy = o_busy;
    end
  end

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int typ, num, busy, base;
    bit bad, got;
    i_rst = 1'b1;
    i_operation_valid = 1'b0; i_operation_type = 2'd0;
    i_operation_addr = 24'd0; i_operation_num = 9'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready",  32'(o_operation_ready), 32'd1);
    chk("rst_busy",      32'(o_busy),            32'd0);
    chk("rst_spi_valid", 32'(o_spi_valid),       32'd0);
    chk("rst_rd_valid",  32'(o_read_valid),      32'd0);
    chk("rst_error",     32'(o_error),           32'd0);
    chk("rst_wr_ready",  32'(o_write_ready),     32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;

    fixed_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    issue_op(0, 24'h012345, 4, 0, 1'b0);
    wait_done("read_dir");

    fixed_q = {8'h5A, 8'hA5};
    issue_op(1, 24'h000100, 2, 2, 1'b0);
    wait_done("prog_dir");

    issue_op(2, 24'h010000, 0, 0, 1'b0);
    wait_done("erase_dir");

    issue_op(1, 24'h000200, 3, 0, 1'b1);
    wait_done("prog_bad_eop");

    issue_op(3, 24'h123456, 4, 0, 1'b0);
    @(negedge clk);
    chk("rsvd_err_cycle1", 32'(o_error), 32'd0);
    @(negedge clk);
    chk("rsvd_err_cycle2", 32'(o_error), 32'd1);
    wait_done("rsvd");

    issue_op(2, 24'h020000, 0, POLL_MAX, 1'b0);
    wait_done("poll_timeout");

    issue_op(1, 24'h0000F0, 1, POLL_MAX - 1, 1'b0);
    wait_done("poll_last_ok");

    issue_op(0, 24'h000000, 0, 0, 1'b0);
    wait_done("read_num0");
    issue_op(1, 24'h000000, 257, 0, 1'b0);
    wait_done("prog_num257");
    issue_op(0, 24'hFFFF00, 256, 0, 1'b0);
    wait_done("read_num256");

    for (int n = 0; n < 30; n++) begin
      typ  = $urandom_range(0, 3);
      num  = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(257, 300))
                                         : $urandom_range(1, 12);
      busy = $urandom_range(0, POLL_MAX);
      bad  = ($urandom_range(0, 4) == 0);
      issue_op(typ, 24'($urandom), num, busy, bad);
      wait_done("random_op");
    end

    base = spi_seen;
    issue_op(0, 24'hABCDEF, 5, 0, 1'b0);
    got = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (spi_seen >= base + 2) begin got = 1'b1; break; end
    end
    chk("reach_addr_phase", 32'(got), 32'd1);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_spi_valid", 32'(o_spi_valid),       32'd0);
    chk("midrst_op_ready",  32'(o_operation_ready), 32'd1);
    chk("midrst_busy",      32'(o_busy),            32'd0);
    spi_q.delete(); rd_q.delete(); wr_q.delete(); err_q.delete();
    @(posedge clk); #1;
    i_rst = 1'b0;

    issue_op(0, 24'h00FF00, 3, 0, 1'b0);
    wait_done("read_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
